// File: rtl/gpr_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// gpr_wb_arbiter_pkg
//   Shared constants for the GPR write-back arbiter and its scoreboard.
//   - Register file geometry: R0-R14 live in the array, R15 is the PC.
//   - Register file WE3 encoding (active-low pair: 2'b00 writes, 2'b11 idles).
//   - Write-back requester indices (ALU, LOAD, LINK).
// -----------------------------------------------------------------------------
package gpr_wb_arbiter_pkg;

   // Register number that aliases the program counter.
   localparam logic [3:0] REG_PC    = 4'd15;

   // Register file write-enable encoding.
   localparam logic [1:0] WE3_WRITE = 2'b00;
   localparam logic [1:0] WE3_IDLE  = 2'b11;

   // Registers physically held in the array (R0-R14).
   localparam int         NUM_GPR   = 15;

   // Write-back requester indices.
   localparam int         REQ_ALU   = 0;
   localparam int         REQ_LOAD  = 1;
   localparam int         REQ_LINK  = 2;

endpackage : gpr_wb_arbiter_pkg

// File: rtl/gpr_wb_arbiter_scoreboard.sv
// -----------------------------------------------------------------------------
// gpr_scoreboard
//   Busy mask for R0-R14. Decode reserves a destination register, the
//   write-back path clears it, and decode stalls while any of its sources
//   is still busy. R15 (the PC) is never tracked.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   rsv_valid/addr      decode reserves register rsv_addr
//   rsv_ready           reservation accepted (target not busy, or R15)
//   clr_en/clr_addr     write-back handshake to clr_addr this cycle
//   rd_a1, rd_a2        source registers being decoded
//   rd_stall            a decoded source has a write outstanding
// -----------------------------------------------------------------------------
module gpr_scoreboard
   import gpr_wb_arbiter_pkg::*;
#(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rsv_valid,
   input  logic [AW-1:0] rsv_addr,
   output logic          rsv_ready,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_addr,
   input  logic [AW-1:0] rd_a1,
   input  logic [AW-1:0] rd_a2,
   output logic          rd_stall
);

   logic [NUM_GPR-1:0] busy;
   logic [NUM_GPR-1:0] busy_nxt;

   // Full-address view of the mask. The bit for R15 is tied to 0, so a
   // reservation of R15 is always accepted and R15 sources never stall.
   logic [2**AW-1:0]   busy_ext;

   // NOTE: every variable driven in an always_comb gets a default on the first
   // line of the block, so no path can leave it unassigned and infer a latch.
   always_comb begin
      busy_ext              = '0;
      busy_ext[NUM_GPR-1:0] = busy;
   end

   assign rsv_ready = rsv_valid & ~busy_ext[rsv_addr];
   assign rd_stall  = busy_ext[rd_a1] | busy_ext[rd_a2];

   // Clear is applied before set so that a reservation landing on the same
   // edge as the write-back of the previous producer keeps the register busy.
   always_comb begin
      busy_nxt = busy;
      for (int i = 0; i < NUM_GPR; i++) begin
         if (clr_en && (clr_addr == AW'(i))) begin
            busy_nxt[i] = 1'b0;
         end
         if (rsv_ready && (rsv_addr == AW'(i))) begin
            busy_nxt[i] = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // its inputs from before the edge, independent of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

endmodule : gpr_scoreboard

// File: rtl/gpr_wb_arbiter.sv
// -----------------------------------------------------------------------------
// gpr_wb_arbiter
//   Shares the single register-file write port (A3/WD3/WE3) between NREQ
//   write-back requesters, redirects writes to R15 onto the PC-update port
//   and keeps the read-after-write scoreboard used by decode.
//
//   Configuration macro GPR_WB_RR_EN:
//     defined   - round-robin arbitration; the search starts at a pointer
//                 that moves to (granted index + 1) mod NREQ after a grant.
//     undefined - fixed priority LOAD > ALU > LINK (> higher indices).
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/addr/data   per-requester write-back request (packed, i at i*W)
//   req_ready             one-hot grant, transfer on valid & ready
//   gpr_a3/wd3/we3        register file write port, registered (latency 1)
//   pc_wr_en/pc_wr_data   one-cycle PC load for writes addressed to R15
//   rsv_valid/addr/ready  destination reservation from decode
//   rd_a1, rd_a2          decoded source registers
//   rd_stall              a decoded source has a write outstanding
// -----------------------------------------------------------------------------
module gpr_wb_arbiter
   import gpr_wb_arbiter_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int AW   = 4,
   parameter int DW   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   output logic [AW-1:0]    gpr_a3,
   output logic [DW-1:0]    gpr_wd3,
   output logic [1:0]       gpr_we3,
   output logic             pc_wr_en,
   output logic [DW-1:0]    pc_wr_data,
   input  logic             rsv_valid,
   input  logic [AW-1:0]    rsv_addr,
   output logic             rsv_ready,
   input  logic [AW-1:0]    rd_a1,
   input  logic [AW-1:0]    rd_a2,
   output logic             rd_stall
);

   logic [NREQ-1:0] grant;
   logic            found;
   logic            hs;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;
   logic            sel_is_pc;

   // ---------------------------------------------------------------------------
   // Arbitration. The grant is forced low during reset so nothing can be
   // accepted while the output registers are being cleared.
   // ---------------------------------------------------------------------------
`ifdef GPR_WB_RR_EN
   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IDXW-1:0] rr_ptr;
   logic [IDXW-1:0] grant_idx;

   // Visit the requesters in the order ptr, ptr+1, ... (mod NREQ) and grant
   // the first one with a pending write.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i] && (i == (int'(rr_ptr) + k) % NREQ)) begin
               found     = 1'b1;
               grant[i]  = 1'b1;
               grant_idx = IDXW'(i);
            end
         end
      end
      if (rst) begin
         grant = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (hs) begin
         rr_ptr <= (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end
`else
   // LOAD first, then the remaining requesters in index order (ALU, LINK, ...).
   always_comb begin
      grant = '0;
      found = 1'b0;
      if (req_valid[REQ_LOAD]) begin
         grant[REQ_LOAD] = 1'b1;
         found           = 1'b1;
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!found && (i != REQ_LOAD) && req_valid[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
      if (rst) begin
         grant = '0;
      end
   end
`endif

   assign req_ready = grant;
   assign hs        = |grant;

   // One-hot grant selects the winning address and data.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_addr = req_addr[i*AW +: AW];
            sel_data = req_data[i*DW +: DW];
         end
      end
   end

   assign sel_is_pc = (sel_addr == AW'(REG_PC));

   // ---------------------------------------------------------------------------
   // Write port and PC port registers. WE3 and the PC strobe fall back to idle
   // every cycle without a handshake; A3/WD3/PC data hold their last value.
   // An asynchronous reset drops WE3 to idle immediately, so a write that was
   // being presented is never committed by the following edge.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gpr_we3    <= WE3_IDLE;
         gpr_a3     <= '0;
         gpr_wd3    <= '0;
         pc_wr_en   <= 1'b0;
         pc_wr_data <= '0;
      end else begin
         gpr_we3  <= WE3_IDLE;
         pc_wr_en <= 1'b0;
         if (hs) begin
            if (sel_is_pc) begin
               pc_wr_en   <= 1'b1;
               pc_wr_data <= sel_data;
            end else begin
               gpr_we3 <= WE3_WRITE;
               gpr_a3  <= sel_addr;
               gpr_wd3 <= sel_data;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Scoreboard: every accepted write-back clears its destination.
   // ---------------------------------------------------------------------------
   gpr_scoreboard #(
      .AW (AW)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .rsv_valid (rsv_valid),
      .rsv_addr  (rsv_addr),
      .rsv_ready (rsv_ready),
      .clr_en    (hs),
      .clr_addr  (sel_addr),
      .rd_a1     (rd_a1),
      .rd_a2     (rd_a2),
      .rd_stall  (rd_stall)
   );

endmodule : gpr_wb_arbiter

// File: tb/tb_gpr_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gpr_wb_arbiter
//   Directed scenarios followed by randomized traffic. A reference model
//   (pending writes, busy flags as a plain array, arbitration order as a list)
//   predicts each grant; predicted register-file / PC writes go into a queue
//   that an independent monitor drains whenever the DUT presents a write.
// -----------------------------------------------------------------------------
module tb_gpr_wb_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 4;
   localparam int DW   = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic [AW-1:0]     gpr_a3;
   logic [DW-1:0]     gpr_wd3;
   logic [1:0]        gpr_we3;
   logic              pc_wr_en;
   logic [DW-1:0]     pc_wr_data;
   logic              rsv_valid;
   logic [AW-1:0]     rsv_addr;
   logic              rsv_ready;
   logic [AW-1:0]     rd_a1;
   logic [AW-1:0]     rd_a2;
   logic              rd_stall;

   gpr_wb_arbiter #(
      .NREQ (NREQ),
      .AW   (AW),
      .DW   (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .gpr_a3     (gpr_a3),
      .gpr_wd3    (gpr_wd3),
      .gpr_we3    (gpr_we3),
      .pc_wr_en   (pc_wr_en),
      .pc_wr_data (pc_wr_data),
      .rsv_valid  (rsv_valid),
      .rsv_addr   (rsv_addr),
      .rsv_ready  (rsv_ready),
      .rd_a1      (rd_a1),
      .rd_a2      (rd_a2),
      .rd_stall   (rd_stall)
   );

   always #5 clk = ~clk;

   // Expected write presented on the DUT outputs during cycle 'cyc'.
   typedef struct {
      bit            is_pc;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            cyc;
   } wr_t;

   wr_t exp_q[$];
   int  vectors     = 0;
   int  miscompares = 0;
   int  cyc         = 0;
   int  last_grant  = -1;

   // Reference state.
   bit  busy_m[15];
   int  ptr_m = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] v);
`ifdef GPR_WB_RR_EN
      for (int k = 0; k < NREQ; k++) begin
         if (v[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
      end
`else
      int order[NREQ] = '{1, 0, 2};
      for (int k = 0; k < NREQ; k++) begin
         if (v[order[k]]) return order[k];
      end
`endif
      return -1;
   endfunction

   function automatic bit model_busy(input logic [AW-1:0] a);
      if (a == 4'd15) return 1'b0;
      return busy_m[a];
   endfunction

   task automatic model_reset();
      exp_q.delete();
      foreach (busy_m[i]) busy_m[i] = 1'b0;
      ptr_m      = 0;
      last_grant = -1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i]         = 1'b1;
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   task automatic release_granted();
      if (last_grant >= 0) req_valid[last_grant] = 1'b0;
   endtask

   // One clock with the current inputs: check the combinational outputs
   // against the model, predict the write, advance the model at the edge.
   // Entered and left at posedge+2.
   task automatic cycle();
      logic [NREQ-1:0] exp_rdy;
      bit              exp_rsv;
      bit              exp_stall;
      int              g;
      wr_t             w;
      @(negedge clk);
      #1;
      g       = pick(req_valid);
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      exp_rsv   = rsv_valid && model_busy(rsv_addr) == 1'b0;
      exp_stall = model_busy(rd_a1) || model_busy(rd_a2);
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      check("rsv_ready", 64'(rsv_ready), 64'(exp_rsv));
      check("rd_stall",  64'(rd_stall),  64'(exp_stall));
      if (g >= 0) begin
         w.addr  = req_addr[g*AW +: AW];
         w.data  = req_data[g*DW +: DW];
         w.is_pc = (w.addr == 4'd15);
         w.cyc   = cyc + 1;
         exp_q.push_back(w);
         if (!w.is_pc) busy_m[w.addr] = 1'b0;
         ptr_m = (g + 1) % NREQ;
      end
      if (exp_rsv && rsv_addr != 4'd15) busy_m[rsv_addr] = 1'b1;
      last_grant = g;
      @(posedge clk);
      #2;
   endtask

   // Monitor: samples the write port on every falling edge.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         cyc++;
         check("we3_encoding", 64'(gpr_we3 == 2'b00 || gpr_we3 == 2'b11), 64'd1);
         if (gpr_we3 == 2'b00 || pc_wr_en) begin
            if (exp_q.size() == 0) begin
               check("spurious_we3",   64'(gpr_we3),  64'(2'b11));
               check("spurious_pc_en", 64'(pc_wr_en), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("write_cycle", 64'(cyc), 64'(e.cyc));
               check("pc_wr_en",    64'(pc_wr_en), 64'(e.is_pc));
               check("gpr_we3",     64'(gpr_we3),  e.is_pc ? 64'(2'b11) : 64'(2'b00));
               if (e.is_pc) begin
                  check("pc_wr_data", 64'(pc_wr_data), 64'(e.data));
               end else begin
                  check("gpr_a3",  64'(gpr_a3),  64'(e.addr));
                  check("gpr_wd3", 64'(gpr_wd3), 64'(e.data));
               end
            end
         end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check("missing_write", {62'd0, gpr_we3 == 2'b00, pc_wr_en}, {62'd0, !e.is_pc, e.is_pc});
         end
      end
   end

   initial begin
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      rsv_valid = 1'b0;
      rsv_addr  = '0;
      rd_a1     = '0;
      rd_a2     = '0;
      model_reset();

      // Reset state, with every requester asking: nothing may be granted.
      rst = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), 32'h1111_0000 + DW'(i));
      repeat (2) @(negedge clk);
      #1;
      check("rst_we3",        64'(gpr_we3),    64'(2'b11));
      check("rst_a3",         64'(gpr_a3),     64'd0);
      check("rst_wd3",        64'(gpr_wd3),    64'd0);
      check("rst_pc_wr_en",   64'(pc_wr_en),   64'd0);
      check("rst_pc_wr_data", 64'(pc_wr_data), 64'd0);
      check("rst_req_ready",  64'(req_ready),  64'd0);
      check("rst_rd_stall",   64'(rd_stall),   64'd0);
      @(posedge clk);
      #2;
      req_valid = '0;
      rst       = 1'b0;

      // 1: single ALU write to R3.
      set_req(0, 4'd3, 32'hDEAD_BEEF);
      cycle();
      release_granted();
      cycle();
      cycle();

      // 2: ALU (R1) and LOAD (R2) contend, then six back-to-back contended grants.
      set_req(0, 4'd1, 32'h0000_0A01);
      set_req(1, 4'd2, 32'h0000_0B02);
      repeat (2) begin
         cycle();
         release_granted();
      end
      for (int n = 0; n < 6; n++) begin
         set_req(0, 4'd1, 32'hA000_0000 + DW'(n));
         set_req(1, 4'd2, 32'hB000_0000 + DW'(n));
         cycle();
         release_granted();
      end
      req_valid = '0;
      cycle();

      // 3: LINK write to R15 becomes a PC load.
      set_req(2, 4'd15, 32'h0000_0100);
      cycle();
      release_granted();
      cycle();

      // 4: reserve R5, stall on it, clear it by writing R5; R15 never stalls.
      rsv_valid = 1'b1;
      rsv_addr  = 4'd5;
      cycle();
      rsv_addr  = 4'd15;
      rd_a1     = 4'd5;
      rd_a2     = 4'd15;
      cycle();
      rsv_valid = 1'b0;
      set_req(0, 4'd5, 32'h5555_5555);
      cycle();
      release_granted();
      cycle();

      // 5: reserve and write R7 on the same edge; a second reserve is refused.
      rsv_valid = 1'b1;
      rsv_addr  = 4'd7;
      set_req(0, 4'd7, 32'h7777_7777);
      cycle();
      release_granted();
      rd_a1 = 4'd7;
      cycle();
      rsv_valid = 1'b0;
      set_req(1, 4'd7, 32'h7777_0001);
      cycle();
      release_granted();
      cycle();

      // 6: reset arrives while a register write is being presented.
      rsv_valid = 1'b1;
      rsv_addr  = 4'd9;
      set_req(0, 4'd4, 32'h4444_4444);
      cycle();
      release_granted();
      rsv_valid = 1'b0;
      rd_a1     = 4'd9;
      check("pre_rst_we3", 64'(gpr_we3), 64'(2'b00));
      rst = 1'b1;
      model_reset();
      #1;
      check("async_rst_we3",      64'(gpr_we3),  64'(2'b11));
      check("async_rst_a3",       64'(gpr_a3),   64'd0);
      check("async_rst_rd_stall", 64'(rd_stall), 64'd0);
      set_req(0, 4'd6, 32'h6666_6666);
      #1;
      check("async_rst_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      cycle();
      release_granted();
      cycle();

      // Randomized traffic.
      for (int n = 0; n < 1500; n++) begin
         release_granted();
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               set_req(i, AW'($urandom_range(0, 15)), DW'($urandom()));
            end
         end
         rsv_valid = 1'($urandom_range(0, 1));
         rsv_addr  = AW'($urandom_range(0, 15));
         rd_a1     = AW'($urandom_range(0, 15));
         rd_a2     = AW'($urandom_range(0, 15));
         cycle();
      end

      // Drain.
      release_granted();
      req_valid = '0;
      rsv_valid = 1'b0;
      repeat (3) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_gpr_wb_arbiter

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
Write-back arbiter and scoreboard for the 15-entry general-purpose register file (R0-R14; R15 is the PC and is held outside the array).
- Shares the single register-file write port (A3/WD3/WE3) between N write-back requesters (ALU, load unit, link/branch).
- Redirects writes addressed to R15 onto a dedicated PC-update port.
- Tracks registers that have a write outstanding, so decode can stall on read-after-write hazards.

Parameters:
- NREQ, 3, number of write-back requesters (index 0 = ALU, 1 = LOAD, 2 = LINK).
- AW, 4, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  NREQ  requester i has a write pending.
- req_addr  in  NREQ*AW  destination register per requester, packed with requester i at bits [i*AW +: AW].
- req_data  in  NREQ*DW  write data per requester, packed the same way.
- req_ready  out  NREQ  one-hot grant; the request is accepted on the clock edge where valid and ready are both 1.
- gpr_a3  out  AW  drives the register file A3.
- gpr_wd3  out  DW  drives the register file WD3.
- gpr_we3  out  2  drives the register file WE3; 2'b00 = write, 2'b11 = idle.
- pc_wr_en  out  1  one-cycle pulse that loads the PC.
- pc_wr_data  out  DW  new PC value.
- rsv_valid  in  1  decode reserves a destination register.
- rsv_addr  in  AW  register being reserved.
- rsv_ready  out  1  the reservation is accepted this cycle.
- rd_a1, rd_a2  in  AW  source registers being decoded.
- rd_stall  out  1  at least one decoded source has a write outstanding.

Behaviour:
- Reset (asynchronous, rst=1):
  - gpr_we3=2'b11, gpr_a3=0, gpr_wd3=0.
  - pc_wr_en=0, pc_wr_data=0.
  - Busy mask = 0, priority pointer = 0.
  - req_ready=0 while rst is high.
  - Reset asserted mid-transfer discards the in-flight write; no partial write is permitted.
- Arbitration:
  - Combinational, one grant per cycle.
  - req_ready is asserted only to the requester selected among those with valid=1.
  - A requester must hold valid, addr and data stable until it sees ready.
- Write path, registered, latency 1:
  - A handshake at edge k with addr in 0-14 sets gpr_a3/gpr_wd3 to the granted addr/data and gpr_we3=2'b00 for the cycle after edge k.
  - The register file commits the write at edge k+1.
  - With no handshake, gpr_we3 returns to 2'b11.
- R15 redirect:
  - A handshake at edge k with addr=15 sets pc_wr_en=1 and pc_wr_data=data for one cycle; gpr_we3 stays 2'b11 for that cycle.
  - The register array is never written at index 15.
- Scoreboard (15-bit busy mask):
  - rsv_ready = rsv_valid & (rsv_addr==15 | !busy[rsv_addr]).
  - An accepted reservation with rsv_addr 0-14 sets busy[rsv_addr] at the edge.
  - An R15 reservation is accepted and has no effect on the mask.
  - A write handshake to addr a clears busy[a] at the same edge.
  - If a reservation and a clear hit the same register at the same edge, the set wins.
  - A write to an unreserved register is legal and leaves the mask unchanged.
- Stall:
  - rd_stall = (rd_a1!=15 & busy[rd_a1]) | (rd_a2!=15 & busy[rd_a2]).
  - Combinational; no bypass is provided.
- Back-to-back grants are allowed every cycle; throughput is 1 write per clock.

Optional Feature:
- Macro: GPR_WB_RR_EN.
- Defined: round-robin arbitration.
  - The pointer advances to (granted index + 1) mod NREQ after each handshake.
  - The search starts at the pointer.
- Undefined: fixed priority, LOAD > ALU > LINK.
  - The pointer register is not instantiated.

Decomposition:
- Shared package:
  - Constants: REG_PC = 4'd15, WE3_WRITE = 2'b00, WE3_IDLE = 2'b11, NUM_GPR = 15.
  - Requester index constants: REQ_ALU, REQ_LOAD, REQ_LINK.
- Sub-module: gpr_scoreboard, containing the busy mask, the reserve/clear logic and the stall compare.
- The arbiter and output registers stay in the top module.

Test Plan:
1. Reset, then ALU req addr=3, data=0xDEADBEEF → ready[0] at edge k; gpr_we3=00, gpr_a3=3, gpr_wd3=0xDEADBEEF for one cycle; then gpr_we3=11.
2. ALU (R1) and LOAD (R2) both valid for 2 cycles → fixed priority: LOAD granted first, then ALU. With GPR_WB_RR_EN: order alternates according to the pointer, with no starvation over 6 consecutive requests.
3. LINK req addr=15, data=0x100 → pc_wr_en pulses 1 for one cycle with pc_wr_data=0x100; gpr_we3 stays 11.
4. Reserve R5, then rd_a1=5 → rd_stall=1. Write R5 → busy clears and rd_stall=0 the next cycle. rd_a2=15 never stalls.
5. Reserve R7 and write R7 at the same edge → busy[7] remains 1. A second reserve of R7 → rsv_ready=0.
6. Assert rst asynchronously between edges while gpr_we3=00 → gpr_we3 goes to 11 immediately; busy mask = 0; no write is committed.
